// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Fetches only need halfword alignment (compressed ISA); data accesses
  // must be naturally aligned and size 3 is never legal.
  function automatic logic misaligned(input logic is_d, input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (!is_d) begin
      bad = addr_lo[0];
    end else begin
      case (size)
        SZ_B:    bad = 1'b0;
        SZ_H:    bad = addr_lo[0];
        SZ_W:    bad = (addr_lo != 2'b00);
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable saturating up-counter with clear and enable; expire_o is high
// while the count sits at LIMIT.
module mem_arb_timer #(
  parameter int LIMIT = 15,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] r_cnt;

  // Count enabled cycles, holding at LIMIT; clear has priority over load.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (en_i && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign expire_o = (r_cnt == LIM);

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates the single-ported unified memory between instruction fetch (I)
// and load/store (D), one outstanding transaction at a time, with alignment
// checking and a response timeout.
//
// Handshake: a requester raises req with stable fields and holds them until
// its gnt pulses (gnt mirrors mem_gnt_i while that requester owns the bus in
// ISSUE). Exactly one rvalid pulse follows each accepted or rejected request;
// err qualifies it, and rdata is only meaningful when rvalid=1 and err=0.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [1:0]        d_size_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [1:0]        mem_size_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        dbg_state_o
);

  localparam int             BW        = $clog2(MAX_D_BURST + 1);
  localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_D_BURST);
  localparam int             TW        = $clog2(TIMEOUT_CYC);

  state_t            r_state;
  state_t            w_next_state;
  owner_t            r_owner;
  logic              r_we;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BW-1:0]     r_burst_cnt;

  logic w_any_req;
  logic w_pick_d;
  logic w_win_misal;
  logic w_tmr_expire;
  logic w_issue;
  logic w_resp_hit;
  logic w_err;
  logic w_own_d;

  // D normally wins; I is forced through once D has had its burst quota.
  assign w_any_req   = i_req_i | d_req_i;
  assign w_pick_d    = d_req_i && !(i_req_i && (r_burst_cnt == BURST_MAX));
  assign w_win_misal = misaligned(w_pick_d, d_size_i,
                                  w_pick_d ? d_addr_i[1:0] : i_addr_i[1:0]);

  // Timeout: limit is TIMEOUT_CYC-1 so expiry lands on the TIMEOUT_CYC-th
  // cycle spent in ISSUE/RESP.
  mem_arb_timer #(
    .LIMIT (TIMEOUT_CYC - 1),
    .W     (TW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (r_state == ST_IDLE),
    .load_i     (1'b0),
    .load_val_i ({TW{1'b0}}),
    .en_i       ((r_state == ST_ISSUE) || (r_state == ST_RESP)),
    .expire_o   (w_tmr_expire)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; a response arriving on the expiry cycle beats the timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_next_state = w_win_misal ? ST_ERR : ST_ISSUE;
      ST_ISSUE: begin
        if (w_tmr_expire)   w_next_state = ST_ERR;
        else if (mem_gnt_i) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        if (mem_rvalid_i)      w_next_state = ST_IDLE;
        else if (w_tmr_expire) w_next_state = ST_ERR;
      end
      ST_ERR:   w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Latch the winning request's fields when leaving IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner <= OWN_I;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if ((r_state == ST_IDLE) && w_any_req) begin
      r_owner <= w_pick_d ? OWN_D : OWN_I;
      r_we    <= w_pick_d & d_we_i;
      r_size  <= w_pick_d ? d_size_i : SZ_W;
      r_addr  <= w_pick_d ? d_addr_i : i_addr_i;
      r_wdata <= w_pick_d ? d_wdata_i : '0;
    end
  end

  // Burst counter: counts D wins against a waiting I, cleared by an I win
  // or by any cycle where I is not requesting.
  always_ff @(posedge clk_i) begin
    if (rst_i || !i_req_i) begin
      r_burst_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (!w_pick_d)                     r_burst_cnt <= '0;
      else if (r_burst_cnt != BURST_MAX) r_burst_cnt <= r_burst_cnt + BW'(1);
    end
  end

  assign w_issue    = (r_state == ST_ISSUE);
  assign w_resp_hit = (r_state == ST_RESP) && mem_rvalid_i;
  assign w_err      = (r_state == ST_ERR);
  assign w_own_d    = (r_owner == OWN_D);

  assign mem_req_o   = w_issue;
  assign mem_we_o    = w_issue & r_we;
  assign mem_size_o  = w_issue ? r_size  : '0;
  assign mem_addr_o  = w_issue ? r_addr  : '0;
  assign mem_wdata_o = w_issue ? r_wdata : '0;

  assign i_gnt_o    = w_issue & mem_gnt_i & !w_own_d;
  assign i_rvalid_o = (w_resp_hit | w_err) & !w_own_d;
  assign i_err_o    = w_err & !w_own_d;
  assign i_rdata_o  = (w_resp_hit && !w_own_d) ? mem_rdata_i : '0;

  assign d_gnt_o    = w_issue & mem_gnt_i & w_own_d;
  assign d_rvalid_o = (w_resp_hit | w_err) & w_own_d;
  assign d_err_o    = w_err & w_own_d;
  assign d_rdata_o  = (w_resp_hit && w_own_d) ? mem_rdata_i : '0;

  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: fetch, burst fairness, alignment errors,
// timeout, response/timeout tie and reset mid-transaction.
module tb_mem_port_arb;
  import mem_arb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i, d_we_i;
  logic [1:0]  d_size_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [1:0]  mem_size_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  dbg_state_o;

  int total = 0;
  int bad   = 0;

  mem_port_arb #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16), .MAX_D_BURST(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock.
  always #5 clk_i = ~clk_i;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-wait transaction from the current ISSUE cycle: gnt now, rvalid next.
  task automatic finish_txn(input logic [31:0] rdata);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  bit          exp_is_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  logic [1:0]  mis_size [5]  = '{2'd3, 2'd1, 2'd0, 2'd1, 2'd2};
  logic [31:0] mis_addr [5]  = '{32'h000, 32'h201, 32'h203, 32'h202, 32'h204};
  bit          mis_err  [5]  = '{1, 1, 0, 0, 0};

  initial begin
    int cnt_req, cnt_gnt, cnt_rv;
    rst_i = 1'b1;
    i_req_i = 1'b0; i_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_size_i = '0; d_addr_i = '0; d_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    tick(); tick();

    // Reset state.
    chk("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_i_rvalid", 32'(i_rvalid_o), 0);
    chk("rst_d_rvalid", 32'(d_rvalid_o), 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    rst_i = 1'b0;
    tick();

    // I-only fetch at 0x100, zero-wait memory.
    i_req_i = 1'b1; i_addr_i = 32'h100;
    tick();
    mem_gnt_i = 1'b1;
    settle();
    chk("f_mem_req", 32'(mem_req_o), 1);
    chk("f_mem_addr", mem_addr_o, 32'h100);
    chk("f_mem_we", 32'(mem_we_o), 0);
    chk("f_mem_size", 32'(mem_size_o), 32'(SZ_W));
    chk("f_i_gnt", 32'(i_gnt_o), 1);
    chk("f_d_gnt", 32'(d_gnt_o), 0);
    i_req_i = 1'b0;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0513;
    settle();
    chk("f_i_rvalid", 32'(i_rvalid_o), 1);
    chk("f_i_rdata", i_rdata_o, 32'h0000_0513);
    chk("f_i_err", 32'(i_err_o), 0);
    chk("f_d_rvalid", 32'(d_rvalid_o), 0);
    chk("f_resp_mem_req", 32'(mem_req_o), 0);
    tick();
    mem_rvalid_i = 1'b0;
    settle();
    chk("f_idle_rvalid", 32'(i_rvalid_o), 0);
    chk("f_idle_rdata", i_rdata_o, 0);

    // Continuous I and D: expect D,D,D,D,I,D,D,D,D,I.
    i_req_i = 1'b1; i_addr_i = 32'h400;
    d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = SZ_W; d_addr_i = 32'h800;
    for (int k = 0; k < 10; k++) begin
      tick();
      mem_gnt_i = 1'b1;
      settle();
      chk($sformatf("b%0d_d_gnt", k), 32'(d_gnt_o), 32'(exp_is_d[k]));
      chk($sformatf("b%0d_i_gnt", k), 32'(i_gnt_o), 32'(!exp_is_d[k]));
      chk($sformatf("b%0d_addr", k), mem_addr_o, exp_is_d[k] ? 32'h800 : 32'h400);
      tick();
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1000 + 32'(k);
      settle();
      chk($sformatf("b%0d_rv", k), 32'(exp_is_d[k] ? d_rvalid_o : i_rvalid_o), 1);
      chk($sformatf("b%0d_rdata", k), exp_is_d[k] ? d_rdata_o : i_rdata_o, 32'h1000 + 32'(k));
      tick();
      mem_rvalid_i = 1'b0;
    end
    i_req_i = 1'b0; d_req_i = 1'b0;
    tick();

    // D word load at 0x202: immediate error, no memory request.
    d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = SZ_W; d_addr_i = 32'h202;
    tick();
    chk("ma_state", 32'(dbg_state_o), 32'(ST_ERR));
    chk("ma_d_rvalid", 32'(d_rvalid_o), 1);
    chk("ma_d_err", 32'(d_err_o), 1);
    chk("ma_d_gnt", 32'(d_gnt_o), 0);
    chk("ma_mem_req", 32'(mem_req_o), 0);
    chk("ma_i_rvalid", 32'(i_rvalid_o), 0);
    d_req_i = 1'b0;
    tick();
    chk("ma_after_rvalid", 32'(d_rvalid_o), 0);
    // Halfword-aligned fetch at 0x002 is legal.
    i_req_i = 1'b1; i_addr_i = 32'h002;
    tick();
    mem_gnt_i = 1'b1;
    settle();
    chk("h_mem_req", 32'(mem_req_o), 1);
    chk("h_mem_addr", mem_addr_o, 32'h002);
    chk("h_i_gnt", 32'(i_gnt_o), 1);
    i_req_i = 1'b0;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    settle();
    chk("h_i_rvalid", 32'(i_rvalid_o), 1);
    chk("h_i_err", 32'(i_err_o), 0);
    chk("h_i_rdata", i_rdata_o, 32'hDEAD_BEEF);
    tick();
    mem_rvalid_i = 1'b0;

    // Odd fetch address is an I error.
    i_req_i = 1'b1; i_addr_i = 32'h101;
    tick();
    chk("im_i_err", 32'(i_err_o), 1);
    chk("im_i_rvalid", 32'(i_rvalid_o), 1);
    chk("im_d_rvalid", 32'(d_rvalid_o), 0);
    i_req_i = 1'b0;
    tick();

    // D alignment table.
    for (int v = 0; v < 5; v++) begin
      d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = mis_size[v]; d_addr_i = mis_addr[v];
      tick();
      chk($sformatf("al%0d_state", v), 32'(dbg_state_o),
          mis_err[v] ? 32'(ST_ERR) : 32'(ST_ISSUE));
      chk($sformatf("al%0d_mem_req", v), 32'(mem_req_o), 32'(!mis_err[v]));
      d_req_i = 1'b0;
      if (mis_err[v]) tick();
      else begin
        chk($sformatf("al%0d_size", v), 32'(mem_size_o), 32'(mis_size[v]));
        finish_txn(32'h55);
      end
    end

    // D store with memory never granting: timeout after 16 request cycles.
    d_req_i = 1'b1; d_we_i = 1'b1; d_size_i = SZ_W; d_addr_i = 32'h300;
    d_wdata_i = 32'hCAFE_F00D;
    tick();
    chk("to_mem_we", 32'(mem_we_o), 1);
    chk("to_mem_wdata", mem_wdata_o, 32'hCAFE_F00D);
    cnt_req = 0; cnt_gnt = 0; cnt_rv = 0;
    for (int c = 0; c < 16; c++) begin
      if (mem_req_o) cnt_req++;
      if (d_gnt_o) cnt_gnt++;
      if (d_rvalid_o) cnt_rv++;
      tick();
    end
    chk("to_req_cycles", 32'(cnt_req), 16);
    chk("to_gnt_pulses", 32'(cnt_gnt), 0);
    chk("to_early_rvalid", 32'(cnt_rv), 0);
    chk("to_mem_req_drop", 32'(mem_req_o), 0);
    chk("to_d_rvalid", 32'(d_rvalid_o), 1);
    chk("to_d_err", 32'(d_err_o), 1);
    chk("to_d_gnt", 32'(d_gnt_o), 0);
    d_req_i = 1'b0;
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234;
    settle();
    chk("stray_d_rvalid", 32'(d_rvalid_o), 0);
    chk("stray_i_rvalid", 32'(i_rvalid_o), 0);
    chk("stray_d_rdata", d_rdata_o, 0);
    chk("stray_state", 32'(dbg_state_o), 32'(ST_IDLE));
    tick();
    mem_rvalid_i = 1'b0;

    // Response on the expiry cycle (16th in ISSUE/RESP) beats the timeout.
    d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = SZ_W; d_addr_i = 32'h304;
    tick();
    mem_gnt_i = 1'b1;
    settle();
    chk("tie_d_gnt", 32'(d_gnt_o), 1);
    d_req_i = 1'b0;
    tick();
    mem_gnt_i = 1'b0;
    for (int c = 0; c < 14; c++) tick();
    chk("tie_state_resp", 32'(dbg_state_o), 32'(ST_RESP));
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A5_5A5A;
    settle();
    chk("tie_d_rvalid", 32'(d_rvalid_o), 1);
    chk("tie_d_err", 32'(d_err_o), 0);
    chk("tie_d_rdata", d_rdata_o, 32'hA5A5_5A5A);
    tick();
    mem_rvalid_i = 1'b0;
    settle();
    chk("tie_state_idle", 32'(dbg_state_o), 32'(ST_IDLE));
    chk("tie_no_err", 32'(d_rvalid_o), 0);

    // Reset while in RESP.
    i_req_i = 1'b1; i_addr_i = 32'h500;
    tick();
    mem_gnt_i = 1'b1;
    i_req_i = 1'b0;
    tick();
    mem_gnt_i = 1'b0;
    chk("rr_in_resp", 32'(dbg_state_o), 32'(ST_RESP));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rr_state", 32'(dbg_state_o), 32'(ST_IDLE));
    chk("rr_mem_req", 32'(mem_req_o), 0);
    chk("rr_i_rvalid", 32'(i_rvalid_o), 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    settle();
    chk("rr_late_i_rvalid", 32'(i_rvalid_o), 0);
    chk("rr_late_d_rvalid", 32'(d_rvalid_o), 0);
    chk("rr_late_i_rdata", i_rdata_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
    chk("rr_final_state", 32'(dbg_state_o), 32'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
